// File: rtl/nios2_oci_trace_pkg.sv
// Shared definitions for the OCI trace capture stage: state encodings and
// small constant/arithmetic helpers used by the FIFO and the top level.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENDING = 2'd1,
    ST_DONE   = 2'd2,
    ST_ABORT  = 2'd3
  } trace_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = {64{1'b1}} >> (64 - width);
    return (value >= max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo.sv
// First-word-fall-through FIFO: array storage with a registered head entry,
// so a word pushed in one cycle is visible at rd_data in the next.
module nios2_oci_trace_fifo
  import nios2_oci_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34,
  localparam int AW    = clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_inc;
  logic [LVL_W-1:0] level_reg;
  logic [WIDTH-1:0] head_reg;
  logic             do_push;
  logic             do_pop;

  assign empty      = (level_reg == '0);
  assign full       = (level_reg == LVL_W'(DEPTH));
  assign do_pop     = pop & ~empty;
  assign do_push    = push & (~full | do_pop);
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);
  assign level      = level_reg;
  assign rd_data    = head_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      if (do_push && !do_pop) begin
        level_reg <= level_reg + LVL_W'(1);
      end else if (do_pop && !do_push) begin
        level_reg <= level_reg - LVL_W'(1);
      end
      // Incoming word bypasses storage when it becomes the new head.
      if (do_push && (empty || (do_pop && level_reg == LVL_W'(1)))) begin
        head_reg <= wr_data;
      end else if (do_pop && level_reg > LVL_W'(1)) begin
        head_reg <= mem[rd_ptr_inc];
      end
    end
  end

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Capture stage for Nios II OCI compressed trace frames: write gating,
// frame/drop accounting and the end-of-test drain/abort state machine.
module nios2_oci_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int DCT_W     = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int TOT_W     = 32,
  parameter bit DROP_ZERO = 1'b1,
  localparam int LVL_W    = clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DCT_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]       dct_count,
  input  logic                   dct_valid,
  input  logic                   test_ending,
  input  logic                   test_has_ended,
  output logic [DCT_W+CNT_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [LVL_W-1:0]       fill_level,
  output logic [TOT_W-1:0]       frame_total,
  output logic [TOT_W-1:0]       drop_count,
  output logic                   overflow,
  output logic [1:0]             state,
  output logic                   trace_done
);

  trace_state_t     state_reg;
  trace_state_t     state_next;
  logic [TOT_W-1:0] frame_total_reg;
  logic [TOT_W-1:0] drop_count_reg;
  logic             overflow_reg;
  logic             trace_done_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_clr;
  logic             rd_fire;
  logic             candidate;
  logic             wr_en;
  logic             drop_en;

  assign rd_valid  = ~fifo_empty;
  assign rd_fire   = rd_valid & rd_ready;
  assign fifo_clr  = (state_reg == ST_ABORT);
  // An abrupt end in this cycle already blocks the frame, keeping counters frozen.
  assign candidate = dct_valid && (state_reg == ST_RUN) && !test_has_ended &&
                     !(DROP_ZERO && (dct_count == '0));
  assign wr_en     = candidate & (~fifo_full | rd_fire);
  assign drop_en   = candidate & fifo_full & ~rd_fire;

  nios2_oci_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DCT_W + CNT_W)
  ) u_fifo (
    .clk     (clk),
    .srst    (reset),
    .clr     (fifo_clr),
    .push    (wr_en),
    .wr_data ({dct_count, dct_buffer}),
    .pop     (rd_ready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  always_comb begin
    state_next = state_reg;
    if (test_has_ended) begin
      state_next = ST_ABORT;
    end else begin
      case (state_reg)
        ST_RUN:    if (test_ending) state_next = ST_ENDING;
        ST_ENDING: if (fill_level == '0) state_next = ST_DONE;
        default:   state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      trace_done_reg  <= 1'b0;
      frame_total_reg <= '0;
      drop_count_reg  <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      trace_done_reg <= (state_next == ST_DONE) || (state_next == ST_ABORT);
      if (wr_en) begin
        frame_total_reg <= TOT_W'(sat_inc(64'(frame_total_reg), TOT_W));
      end
      if (drop_en) begin
        drop_count_reg <= TOT_W'(sat_inc(64'(drop_count_reg), TOT_W));
        overflow_reg   <= 1'b1;
      end
    end
  end

  assign state       = state_reg;
  assign trace_done  = trace_done_reg;
  assign frame_total = frame_total_reg;
  assign drop_count  = drop_count_reg;
  assign overflow    = overflow_reg;

endmodule
